// File: rtl/product_accumulator.sv
// Sums LEN unsigned multiplier products into a saturating ACC_W-bit result,
// with valid/ready handshakes on both the product input and the result output.
module product_accumulator #(
  parameter int N     = 8,
  parameter int ACC_W = 24,
  parameter int LEN   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     p_valid,
  output logic                     p_ready,
  input  logic [2*N-1:0]           p_data,
  output logic                     acc_valid,
  input  logic                     acc_ready,
  output logic [ACC_W-1:0]         acc_data,
  output logic                     acc_ovf,
  output logic                     busy,
  output logic [$clog2(LEN+1)-1:0] term_cnt
);

  localparam int PW = 2 * N;
  localparam int CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(LEN - 1);
  localparam logic [ACC_W-1:0] SAT_VAL = '1;

  generate
    if (ACC_W < PW) begin : g_bad_acc_w
      $error("product_accumulator: ACC_W (%0d) must be >= 2*N (%0d)", ACC_W, PW);
    end
    if (N < 2) begin : g_bad_n
      $error("product_accumulator: N (%0d) must be >= 2", N);
    end
    if (LEN < 1) begin : g_bad_len
      $error("product_accumulator: LEN (%0d) must be >= 1", LEN);
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t state;
  logic accept;
  logic [ACC_W:0] sum;

  assign accept = p_valid && p_ready;

  // One extra bit catches the carry out, which is the saturation trigger.
  assign sum = {1'b0, acc_data} + {{(ACC_W + 1 - PW){1'b0}}, p_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc_data  <= '0;
      acc_ovf   <= 1'b0;
      term_cnt  <= '0;
      p_ready   <= 1'b0;
      acc_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACCUM;
            acc_data <= '0;
            acc_ovf  <= 1'b0;
            term_cnt <= '0;
            p_ready  <= 1'b1;
            busy     <= 1'b1;
          end
        end

        ACCUM: begin
          if (accept) begin
            term_cnt <= term_cnt + CW'(1);
            // Once saturated, stay pinned at all-ones for the rest of the run.
            if (sum[ACC_W] || acc_ovf) begin
              acc_data <= SAT_VAL;
              acc_ovf  <= 1'b1;
            end else begin
              acc_data <= sum[ACC_W-1:0];
            end
            if (term_cnt == LAST_CNT) begin
              state     <= DONE;
              p_ready   <= 1'b0;
              acc_valid <= 1'b1;
            end
          end
        end

        DONE: begin
          if (acc_ready) begin
            acc_valid <= 1'b0;
            if (start) begin
              state    <= ACCUM;
              acc_data <= '0;
              acc_ovf  <= 1'b0;
              term_cnt <= '0;
              p_ready  <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state     <= IDLE;
          p_ready   <= 1'b0;
          acc_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator (N=4, ACC_W=9, LEN=3): expected results
// are queued as products are driven and popped when the DUT presents a result.
module tb_product_accumulator;

  localparam int N     = 4;
  localparam int ACC_W = 9;
  localparam int LEN   = 3;
  localparam int PW    = 2 * N;
  localparam int CW    = $clog2(LEN + 1);
  localparam int MAXV  = (1 << ACC_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic p_valid = 1'b0;
  logic acc_ready = 1'b0;
  logic [PW-1:0] p_data = '0;
  logic p_ready, acc_valid, acc_ovf, busy;
  logic [ACC_W-1:0] acc_data;
  logic [CW-1:0] term_cnt;

  int total = 0;
  int bad = 0;

  typedef struct {
    int data;
    int ovf;
  } result_t;

  result_t sb[$];
  result_t last_exp;
  int model_sum;
  int model_cnt;
  int model_ovf;

  always #5 clk = ~clk;

  product_accumulator #(.N(N), .ACC_W(ACC_W), .LEN(LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .p_valid   (p_valid),
    .p_ready   (p_ready),
    .p_data    (p_data),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .acc_data  (acc_data),
    .acc_ovf   (acc_ovf),
    .busy      (busy),
    .term_cnt  (term_cnt)
  );

  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resetModel();
    model_sum = 0;
    model_cnt = 0;
    model_ovf = 0;
  endtask

  // Start a run from IDLE and confirm the run-start clearing.
  task automatic beginRun();
    start = 1'b1;
    step();
    start = 1'b0;
    resetModel();
    checkOutput("start_busy", busy, 1);
    checkOutput("start_p_ready", p_ready, 1);
    checkOutput("start_acc_data", acc_data, 0);
    checkOutput("start_term_cnt", term_cnt, 0);
  endtask

  task automatic applyStimulus(input int v);
    p_valid = 1'b1;
    p_data  = PW'(v);
    step();
    p_valid = 1'b0;
    if (model_ovf != 0 || model_sum + v > MAXV) begin
      model_sum = MAXV;
      model_ovf = 1;
    end else begin
      model_sum = model_sum + v;
    end
    model_cnt++;
    checkOutput("term_cnt", term_cnt, model_cnt);
    if (model_cnt == LEN) begin
      last_exp.data = model_sum;
      last_exp.ovf  = model_ovf;
      sb.push_back(last_exp);
    end
  endtask

  task automatic gapCycle();
    p_valid = 1'b0;
    p_data  = PW'($urandom);
    step();
    checkOutput("gap_term_cnt", term_cnt, model_cnt);
    checkOutput("gap_acc_valid", acc_valid, 0);
  endtask

  task automatic checkResult();
    result_t r;
    checkOutput("acc_valid", acc_valid, 1);
    checkOutput("done_term_cnt", term_cnt, LEN);
    checkOutput("done_p_ready", p_ready, 0);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard: result seen with empty queue, got %0d", acc_data);
    end else begin
      r = sb.pop_front();
      last_exp = r;
      checkOutput("acc_data", acc_data, r.data);
      checkOutput("acc_ovf", acc_ovf, r.ovf);
    end
  endtask

  task automatic checkIdle();
    checkOutput("idle_acc_valid", acc_valid, 0);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_acc_data", acc_data, last_exp.data);
  endtask

  initial begin
    $display("[TB] starting product_accumulator bench");
    resetModel();
    #2;
    checkOutput("rst_acc_data", acc_data, 0);
    checkOutput("rst_acc_ovf", acc_ovf, 0);
    checkOutput("rst_term_cnt", term_cnt, 0);
    checkOutput("rst_p_ready", p_ready, 0);
    checkOutput("rst_acc_valid", acc_valid, 0);
    checkOutput("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic run: 15+225+100
    acc_ready = 1'b1;
    beginRun();
    applyStimulus(15);
    applyStimulus(225);
    applyStimulus(100);
    checkResult();
    step();
    checkIdle();

    // Gapped input; junk on p_data while p_valid is low
    beginRun();
    applyStimulus(7);
    gapCycle();
    gapCycle();
    applyStimulus(8);
    gapCycle();
    applyStimulus(9);
    checkResult();
    step();
    checkIdle();

    // Saturation then a clean run
    beginRun();
    applyStimulus(225);
    applyStimulus(225);
    applyStimulus(225);
    checkResult();
    step();
    checkIdle();
    beginRun();
    applyStimulus(1);
    applyStimulus(2);
    applyStimulus(3);
    checkResult();
    step();
    checkIdle();

    // Backpressure with start asserted (must be ignored)
    acc_ready = 1'b0;
    beginRun();
    applyStimulus(10);
    applyStimulus(20);
    applyStimulus(30);
    checkResult();
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      step();
      checkOutput("bp_acc_valid", acc_valid, 1);
      checkOutput("bp_acc_data", acc_data, last_exp.data);
      checkOutput("bp_acc_ovf", acc_ovf, last_exp.ovf);
      checkOutput("bp_p_ready", p_ready, 0);
      checkOutput("bp_term_cnt", term_cnt, LEN);
    end
    start = 1'b0;
    acc_ready = 1'b1;
    step();
    checkIdle();

    // Back-to-back: handshake and start in the same DONE cycle
    acc_ready = 1'b0;
    beginRun();
    applyStimulus(40);
    applyStimulus(50);
    applyStimulus(60);
    checkResult();
    acc_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    resetModel();
    checkOutput("b2b_busy", busy, 1);
    checkOutput("b2b_p_ready", p_ready, 1);
    checkOutput("b2b_acc_valid", acc_valid, 0);
    checkOutput("b2b_acc_data", acc_data, 0);
    checkOutput("b2b_term_cnt", term_cnt, 0);
    applyStimulus(5);
    applyStimulus(6);
    applyStimulus(7);
    checkResult();
    step();
    checkIdle();

    // Reset mid-run, asserted away from a clock edge
    beginRun();
    applyStimulus(100);
    applyStimulus(100);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_acc_data", acc_data, 0);
    checkOutput("mid_rst_term_cnt", term_cnt, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_p_ready", p_ready, 0);
    checkOutput("mid_rst_acc_valid", acc_valid, 0);
    resetModel();
    last_exp.data = 0;
    last_exp.ovf  = 0;
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checkIdle();
    beginRun();
    applyStimulus(1);
    applyStimulus(1);
    applyStimulus(1);
    checkResult();
    step();
    checkIdle();

    checkOutput("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
